// File: rtl/regfile_wide_pkg.sv
// Shared selectors, CPU-stats fields and stack helpers for the 65C2402 register file.
package regfile_wide_pkg;

   localparam int unsigned SEL_Z = 0;
   localparam int unsigned SEL_X = 1;
   localparam int unsigned SEL_Y = 2;
   localparam int unsigned SEL_A = 3;

   localparam logic       AB24 = 1'b1;
   localparam logic [2:0] R08  = 3'b001;

   localparam logic [15:0] SP_RST_DEF = 16'hFFFF;

   typedef enum logic [1:0] {
      SP_HOLD,
      SP_TXS,
      SP_PUSH,
      SP_PULL
   } sp_op_e;

   // A byte count of 0 means a single byte.
   function automatic logic [1:0] stk_dec(input logic [1:0] n);
      return (n == 2'd0) ? 2'd1 : n;
   endfunction

endpackage

// File: rtl/regfile_wide_if.sv
// Control-FSM side bundle of the register file: register ports, stack control, stats load.
interface regfile_wide_if #(
   parameter int unsigned DW   = 8,
   parameter int unsigned NREG = 4,
   parameter int unsigned SW   = 8
);
   localparam int unsigned AW = $clog2(NREG);

   logic          reg_we;
   logic [AW-1:0] reg_src;
   logic [AW-1:0] reg_idx;
   logic [AW-1:0] reg_dst;
   logic [DW-1:0] dst;
   logic [DW-1:0] src;
   logic [DW-1:0] idx;
   logic [SW-1:0] S;
   logic          txs;
   logic          push;
   logic          pull;
   logic [1:0]    stk_n;
   logic          wrap;
   logic          wrap_clr;
   logic          stats_ld;
   logic [DW-1:0] stats_val;

   modport master (
      output reg_we, reg_src, reg_idx, reg_dst, dst,
      output txs, push, pull, stk_n, wrap_clr, stats_ld, stats_val,
      input  src, idx, S, wrap
   );

   modport slave (
      input  reg_we, reg_src, reg_idx, reg_dst, dst,
      input  txs, push, pull, stk_n, wrap_clr, stats_ld, stats_val,
      output src, idx, S, wrap
   );
endinterface

// File: rtl/regfile_sp.sv
// Stack pointer: txs/push/pull priority, byte-count decode and sticky wrap flag.
module regfile_sp
   import regfile_wide_pkg::*;
#(
   parameter int unsigned   SW     = 8,
   parameter logic [SW-1:0] SP_RST = SP_RST_DEF[SW-1:0]
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          txs,
   input  logic          push,
   input  logic          pull,
   input  logic [1:0]    stk_n,
   input  logic [SW-1:0] txs_val,
   input  logic          wrap_clr,
   output logic [SW-1:0] S,
   output logic          wrap
);
   sp_op_e        op;
   logic [SW-1:0] n;
   logic [SW:0]   dec;
   logic [SW:0]   inc;
   logic [SW-1:0] s_nxt;
   logic          wrap_set;

   always_comb begin
      op = SP_HOLD;
      if (txs)       op = SP_TXS;
      else if (push) op = SP_PUSH;
      else if (pull) op = SP_PULL;
   end

   // One guard bit each way: borrow on push, carry on pull.
   assign n   = {{(SW-2){1'b0}}, stk_dec(stk_n)};
   assign dec = {1'b0, S} - {1'b0, n};
   assign inc = {1'b0, S} + {1'b0, n};

   always_comb begin
      s_nxt    = S;
      wrap_set = 1'b0;
      case (op)
         SP_TXS:  s_nxt = txs_val;
         SP_PUSH: begin
            s_nxt    = dec[SW-1:0];
            wrap_set = dec[SW];
         end
         SP_PULL: begin
            s_nxt    = inc[SW-1:0];
            wrap_set = inc[SW];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S    <= SP_RST;
         wrap <= 1'b0;
      end else begin
         S    <= s_nxt;
         wrap <= wrap_set | (wrap & ~wrap_clr);
      end
   end

endmodule

// File: rtl/regfile_wide.sv
// Parametrised register file for the 65C2402 core: general registers, two read ports,
// one write port with optional bypass, stats load into A, and the stack pointer.
module regfile_wide
   import regfile_wide_pkg::*;
#(
   parameter int unsigned   DW     = 8,
   parameter int unsigned   NREG   = 4,
   parameter int unsigned   SW     = 8,
   parameter logic [SW-1:0] SP_RST = SP_RST_DEF[SW-1:0],
   parameter bit            BYPASS = 1'b0,
   parameter int unsigned   A_SEL  = SEL_A
) (
   input logic           clk,
   input logic           rst_n,
   regfile_wide_if.slave bus
);
   localparam int unsigned   AW    = $clog2(NREG);
   localparam logic [AW-1:0] A_IDX = AW'(A_SEL);

   logic [DW-1:0] regs [NREG];
   logic [SW-1:0] txs_val;

   // stats_ld is applied last so it overrides a same-cycle write to A.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '{default: '0};
      end else begin
         if (bus.reg_we)   regs[bus.reg_dst] <= bus.dst;
         if (bus.stats_ld) regs[A_IDX]       <= bus.stats_val;
      end
   end

   always_comb begin
      bus.src = regs[bus.reg_src];
      bus.idx = regs[bus.reg_idx];
      if (BYPASS && bus.reg_we) begin
         if (bus.reg_src == bus.reg_dst) bus.src = bus.dst;
         if (bus.reg_idx == bus.reg_dst) bus.idx = bus.dst;
      end
   end

   generate
      if (SW > DW) begin : g_txs_ext
         assign txs_val = {{(SW-DW){1'b0}}, bus.src};
      end else begin : g_txs_trunc
         assign txs_val = bus.src[SW-1:0];
      end
   endgenerate

   regfile_sp #(
      .SW     (SW),
      .SP_RST (SP_RST)
   ) u_sp (
      .clk      (clk),
      .rst_n    (rst_n),
      .txs      (bus.txs),
      .push     (bus.push),
      .pull     (bus.pull),
      .stk_n    (bus.stk_n),
      .txs_val  (txs_val),
      .wrap_clr (bus.wrap_clr),
      .S        (bus.S),
      .wrap     (bus.wrap)
   );

endmodule

// File: tb/tb_regfile_wide.sv
// Scoreboard bench for regfile_wide: plain, bypass and 16-bit stack instances.
module tb_regfile_wide;
   import regfile_wide_pkg::*;

   typedef enum int unsigned {G_SRC, G_IDX, G_SP, G_WRAP} sig_e;

   typedef struct {
      string       nm;
      int unsigned d;
      sig_e        s;
      logic [15:0] v;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   regfile_wide_if #(.DW(8), .NREG(4), .SW(8))  if0 ();
   regfile_wide_if #(.DW(8), .NREG(4), .SW(8))  if1 ();
   regfile_wide_if #(.DW(8), .NREG(4), .SW(16)) if2 ();

   regfile_wide #(.DW(8), .NREG(4), .SW(8), .BYPASS(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0));
   regfile_wide #(.DW(8), .NREG(4), .SW(8), .BYPASS(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1));
   regfile_wide #(.DW(8), .NREG(4), .SW(16), .BYPASS(1'b0)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(if2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] actual(input int unsigned d, input sig_e s);
      logic [15:0] r;
      r = 16'hDEAD;
      case (d)
         0: case (s)
               G_SRC:  r = 16'(if0.src);
               G_IDX:  r = 16'(if0.idx);
               G_SP:   r = 16'(if0.S);
               G_WRAP: r = 16'(if0.wrap);
               default: ;
            endcase
         1: case (s)
               G_SRC:  r = 16'(if1.src);
               G_IDX:  r = 16'(if1.idx);
               G_SP:   r = 16'(if1.S);
               G_WRAP: r = 16'(if1.wrap);
               default: ;
            endcase
         default: case (s)
               G_SRC:  r = 16'(if2.src);
               G_IDX:  r = 16'(if2.idx);
               G_SP:   r = if2.S;
               G_WRAP: r = 16'(if2.wrap);
               default: ;
            endcase
      endcase
      return r;
   endfunction

   task automatic chk(input string nm, input int unsigned d, input sig_e s, input logic [15:0] v);
      exp_t e;
      e.nm = nm;
      e.d  = d;
      e.s  = s;
      e.v  = v;
      sb.push_back(e);
   endtask

   // Monitor: compares every pending expectation once the outputs have settled.
   initial begin
      exp_t        e;
      logic [15:0] act;
      forever begin
         @(negedge clk or negedge rst_n);
         #1;
         while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = actual(e.d, e.s);
            n_checks++;
            if (act !== e.v) begin
               n_fail++;
               $display("FAIL %s: dut%0d got %h, expected %h", e.nm, e.d, act, e.v);
            end
         end
      end
   end

   task automatic idle_all();
      if0.reg_we = 0; if0.reg_src = 0; if0.reg_idx = 0; if0.reg_dst = 0; if0.dst = 0;
      if0.txs = 0; if0.push = 0; if0.pull = 0; if0.stk_n = 0; if0.wrap_clr = 0;
      if0.stats_ld = 0; if0.stats_val = 0;
      if1.reg_we = 0; if1.reg_src = 0; if1.reg_idx = 0; if1.reg_dst = 0; if1.dst = 0;
      if1.txs = 0; if1.push = 0; if1.pull = 0; if1.stk_n = 0; if1.wrap_clr = 0;
      if1.stats_ld = 0; if1.stats_val = 0;
      if2.reg_we = 0; if2.reg_src = 0; if2.reg_idx = 0; if2.reg_dst = 0; if2.dst = 0;
      if2.txs = 0; if2.push = 0; if2.pull = 0; if2.stk_n = 0; if2.wrap_clr = 0;
      if2.stats_ld = 0; if2.stats_val = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle_all();
   endtask

   initial begin
      rst_n = 1'b1;
      idle_all();
      #2 rst_n = 1'b0;

      step();
      if0.reg_src = 2'(SEL_X); if0.reg_idx = 2'(SEL_A);
      chk("rst_S", 0, G_SP, 16'h00FF);
      chk("rst_wrap", 0, G_WRAP, 16'h0000);
      chk("rst_src", 0, G_SRC, 16'h0000);
      chk("rst_S16", 2, G_SP, 16'hFFFF);

      step();
      rst_n = 1'b1;
      if0.reg_we = 1; if0.reg_dst = 2'(SEL_X); if0.dst = 8'h5A;
      if0.reg_src = 2'(SEL_X); if0.reg_idx = 2'(SEL_A);
      if1.reg_we = 1; if1.reg_dst = 2'(SEL_X); if1.dst = 8'h5A;
      if1.reg_src = 2'(SEL_X); if1.reg_idx = 2'(SEL_A);
      if1.pull = 1; if1.stk_n = 2'd1;
      chk("wr_nobyp_same", 0, G_SRC, 16'h0000);
      chk("wr_byp_same", 1, G_SRC, 16'h005A);
      chk("byp_nomatch_idx", 1, G_IDX, 16'h0000);

      step();
      if0.reg_src = 2'(SEL_X);
      if0.reg_we = 1; if0.reg_dst = 2'(SEL_Z); if0.dst = 8'h02;
      if1.reg_src = 2'(SEL_X);
      chk("wr_nobyp_next", 0, G_SRC, 16'h005A);
      chk("wr_byp_next", 1, G_SRC, 16'h005A);
      chk("pull_carry_S", 1, G_SP, 16'h0000);
      chk("pull_carry_wrap", 1, G_WRAP, 16'h0001);

      step();
      if0.reg_we = 1; if0.reg_dst = 2'(SEL_Y); if0.dst = 8'h80;
      if0.reg_src = 2'(SEL_Z); if0.txs = 1;
      chk("read_z", 0, G_SRC, 16'h0002);

      step();
      if0.push = 1; if0.stk_n = 2'd3;
      chk("txs_S", 0, G_SP, 16'h0002);
      chk("txs_nowrap", 0, G_WRAP, 16'h0000);

      step();
      if0.pull = 1; if0.stk_n = 2'd3;
      chk("push3_S", 0, G_SP, 16'h00FF);
      chk("push3_wrap", 0, G_WRAP, 16'h0001);

      step();
      if0.wrap_clr = 1;
      chk("pull3_S", 0, G_SP, 16'h0002);
      chk("pull3_wrap", 0, G_WRAP, 16'h0001);

      step();
      if0.push = 1; if0.stk_n = 2'd3;
      chk("wrap_clr", 0, G_WRAP, 16'h0000);

      step();
      if0.txs = 1; if0.push = 1; if0.pull = 1; if0.stk_n = 2'd3;
      if0.reg_src = 2'(SEL_Y);
      chk("rewrap_S", 0, G_SP, 16'h00FF);
      chk("rewrap_wrap", 0, G_WRAP, 16'h0001);

      step();
      if0.wrap_clr = 1; if0.txs = 1; if0.reg_src = 2'(SEL_Z);
      chk("prio_txs_S", 0, G_SP, 16'h0080);
      chk("prio_txs_wrap", 0, G_WRAP, 16'h0001);

      step();
      if0.wrap_clr = 1; if0.push = 1; if0.stk_n = 2'd3;
      chk("txs_z_S", 0, G_SP, 16'h0002);
      chk("clr_wrap", 0, G_WRAP, 16'h0000);

      step();
      if0.reg_we = 1; if0.reg_dst = 2'(SEL_Z); if0.dst = 8'h10;
      chk("set_vs_clr_S", 0, G_SP, 16'h00FF);
      chk("set_beats_clr", 0, G_WRAP, 16'h0001);

      step();
      if0.txs = 1; if0.reg_src = 2'(SEL_Z);

      step();
      if0.push = 1; if0.pull = 1; if0.stk_n = 2'd1;
      chk("txs_10", 0, G_SP, 16'h0010);

      step();
      if0.push = 1; if0.stk_n = 2'd0;
      chk("prio_push", 0, G_SP, 16'h000F);

      step();
      if0.reg_we = 1; if0.reg_dst = 2'(SEL_A); if0.dst = 8'h33;
      chk("stk_n0_is1", 0, G_SP, 16'h000E);
      chk("wrap_sticky", 0, G_WRAP, 16'h0001);

      step();
      if0.stats_ld = 1; if0.stats_val = {AB24, R08, 4'h0};
      if0.reg_we = 1; if0.reg_dst = 2'(SEL_Y); if0.dst = 8'h22;
      if0.reg_src = 2'(SEL_A); if0.reg_idx = 2'(SEL_Y);
      chk("a_before_stats", 0, G_SRC, 16'h0033);
      chk("y_before", 0, G_IDX, 16'h0080);

      step();
      if0.stats_ld = 1; if0.stats_val = 8'h90;
      if0.reg_we = 1; if0.reg_dst = 2'(SEL_A); if0.dst = 8'h11;
      if0.reg_src = 2'(SEL_A); if0.reg_idx = 2'(SEL_Y);
      if1.stats_ld = 1; if1.stats_val = 8'h90;
      if1.reg_we = 1; if1.reg_dst = 2'(SEL_A); if1.dst = 8'h11;
      if1.reg_src = 2'(SEL_A);
      chk("stats_a", 0, G_SRC, 16'h0090);
      chk("stats_keeps_y_wr", 0, G_IDX, 16'h0022);
      chk("byp_ignores_stats", 1, G_SRC, 16'h0011);

      step();
      if0.reg_src = 2'(SEL_A);
      if1.reg_src = 2'(SEL_A);
      chk("stats_beats_we", 0, G_SRC, 16'h0090);
      chk("stats_beats_we_byp", 1, G_SRC, 16'h0090);

      step();
      if0.reg_we = 1; if0.reg_dst = 2'(SEL_Z); if0.dst = 8'h40;

      step();
      if0.txs = 1; if0.reg_src = 2'(SEL_Z);

      step();
      if0.reg_src = 2'(SEL_X); if0.reg_idx = 2'(SEL_A);
      chk("pre_rst_S", 0, G_SP, 16'h0040);
      chk("pre_rst_src", 0, G_SRC, 16'h005A);
      @(negedge clk);
      #2;
      chk("midrst_S", 0, G_SP, 16'h00FF);
      chk("midrst_wrap", 0, G_WRAP, 16'h0000);
      chk("midrst_src_x", 0, G_SRC, 16'h0000);
      chk("midrst_idx_a", 0, G_IDX, 16'h0000);
      rst_n = 1'b0;

      step();
      rst_n = 1'b1;
      if2.reg_we = 1; if2.reg_dst = 2'(SEL_Z); if2.dst = 8'h01;

      step();
      if2.txs = 1; if2.reg_src = 2'(SEL_Z);

      step();
      if2.push = 1; if2.stk_n = 2'd2;
      chk("sw16_txs", 2, G_SP, 16'h0001);
      chk("sw16_nowrap", 2, G_WRAP, 16'h0000);

      step();
      if2.reg_we = 1; if2.reg_dst = 2'(SEL_X); if2.dst = 8'h7F;
      chk("sw16_push2_S", 2, G_SP, 16'hFFFF);
      chk("sw16_push2_wrap", 2, G_WRAP, 16'h0001);

      step();
      if2.txs = 1; if2.reg_src = 2'(SEL_X);

      step();
      chk("sw16_txs_ext", 2, G_SP, 16'h007F);
      chk("sw16_txs_keeps_wrap", 2, G_WRAP, 16'h0001);

      for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
      #2;
      if (sb.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
